// File: rtl/arith_encoder_param.sv
// arith_encoder_param: integer arithmetic encoder with a programmable static
// frequency table. Symbols arrive on a valid/ready handshake, code bits leave
// as a serial valid/ready stream. Every BLOCK_LEN symbols the block is closed
// with a termination sequence, terminate_flag pulses and the coder restarts.
//
// Ports:
//   sys_clk, sys_reset        clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_freq  frequency table write (IDLE only)
//   cfg_start                 build cumulative table, then start coding
//   sym_in/sym_valid/sym_ready  symbol input handshake
//   bit_out/bit_valid/bit_ready code bit output handshake
//   terminate_flag            1-cycle pulse after a block's last bit
//   busy                      coder not in IDLE
//   cfg_error                 sticky: table total wrong, cleared by cfg_start
//   sym_error                 1-cycle pulse: zero-frequency symbol dropped
module arith_encoder_param #(
    parameter int SYM_W     = 3,
    parameter int N         = 8,
    parameter int TOT_W     = 3,
    parameter int BLOCK_LEN = 96
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             cfg_we,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [TOT_W:0]   cfg_freq,
    input  logic             cfg_start,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             terminate_flag,
    output logic             busy,
    output logic             cfg_error,
    output logic             sym_error
);
    localparam int NSYM  = 1 << SYM_W;
    localparam int CW    = TOT_W + 2;
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int PW    = N + 1 + CW;

    localparam logic [N-1:0]     HALF  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     QTR   = {2'b01, {(N-2){1'b0}}};
    localparam logic [N-1:0]     TQTR  = {2'b11, {(N-2){1'b0}}};
    localparam logic [CW-1:0]    TOTAL = CW'(1) << TOT_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CUMSUM = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_SCALE  = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;
    localparam logic [2:0] S_EMIT   = 3'd6;

    logic [2:0]       state;
    logic [TOT_W:0]   freq [0:NSYM-1];
    logic [CW-1:0]    cum  [0:NSYM];   // cum[0] is never written and stays 0
    logic [SYM_W-1:0] idx;
    logic             ovf;
    logic [N-1:0]     low, high, pending;
    logic [CNT_W-1:0] count;
    logic [SYM_W-1:0] sym_q;
    logic             follow;          // value of the pending bits after the lead bit
    logic             flushing;        // current emission closes the block

    logic [SYM_W:0]   idx_nxt, s_nxt;
    logic [CW:0]      sum_n;
    logic [N:0]       rng;
    logic [PW-1:0]    prod_lo, prod_hi;
    logic [N-1:0]     low_n, high_n, lo_m, hi_m, pend_inc;

    always_comb begin
        idx_nxt  = {1'b0, idx} + 1'b1;
        s_nxt    = {1'b0, sym_q} + 1'b1;
        sum_n    = {1'b0, cum[idx]} + {2'b00, freq[idx]};
        rng      = {1'b0, high} - {1'b0, low} + 1'b1;
        prod_lo  = PW'(rng) * PW'(cum[sym_q]);
        prod_hi  = PW'(rng) * PW'(cum[s_nxt]);
        // Truncation is modular: when cum[s+1] is the full total the quotient
        // equals the range, which may not fit in N bits, but low+q-1 does.
        low_n    = low + N'(prod_lo >> TOT_W);
        high_n   = low + N'(prod_hi >> TOT_W) - 1'b1;
        lo_m     = low - QTR;
        hi_m     = high - QTR;
        pend_inc = (&pending) ? pending : pending + 1'b1;
    end

    assign sym_ready = (state == S_READY);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state          <= S_IDLE;
            for (int i = 0; i < NSYM; i++) freq[i] <= '0;
            for (int i = 0; i <= NSYM; i++) cum[i] <= '0;
            idx            <= '0;
            ovf            <= 1'b0;
            low            <= '0;
            high           <= '1;
            pending        <= '0;
            count          <= '0;
            sym_q          <= '0;
            follow         <= 1'b0;
            flushing       <= 1'b0;
            bit_out        <= 1'b0;
            bit_valid      <= 1'b0;
            terminate_flag <= 1'b0;
            cfg_error      <= 1'b0;
            sym_error      <= 1'b0;
        end else begin
            terminate_flag <= 1'b0;
            sym_error      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_we) freq[cfg_addr] <= cfg_freq;
                    if (cfg_start) begin
                        cfg_error <= 1'b0;
                        idx       <= '0;
                        ovf       <= 1'b0;
                        state     <= S_CUMSUM;
                    end
                end
                S_CUMSUM: begin
                    cum[idx_nxt] <= sum_n[CW-1:0];
                    ovf          <= ovf | sum_n[CW];
                    idx          <= idx + 1'b1;
                    if (&idx) begin
                        // A wrapped running sum must not masquerade as a valid total.
                        if (ovf || sum_n[CW] || sum_n[CW-1:0] != TOTAL) begin
                            cfg_error <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state     <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (sym_valid) begin
                        if (freq[sym_in] == '0) begin
                            sym_error <= 1'b1;
                        end else begin
                            sym_q <= sym_in;
                            state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    low   <= low_n;
                    high  <= high_n;
                    count <= count + 1'b1;
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    if (high < HALF || low >= HALF) begin
                        // Doubling after removing HALF equals dropping the MSB.
                        bit_out   <= (low >= HALF);
                        follow    <= !(low >= HALF);
                        bit_valid <= 1'b1;
                        low       <= {low[N-2:0], 1'b0};
                        high      <= {high[N-2:0], 1'b1};
                        state     <= S_EMIT;
                    end else if (low >= QTR && high < TQTR) begin
                        pending   <= pend_inc;
                        low       <= {lo_m[N-2:0], 1'b0};
                        high      <= {hi_m[N-2:0], 1'b1};
                    end else begin
                        state     <= (count == LAST) ? S_FLUSH : S_READY;
                    end
                end
                S_FLUSH: begin
                    pending   <= pend_inc;
                    bit_out   <= !(low < QTR);
                    follow    <= (low < QTR);
                    bit_valid <= 1'b1;
                    flushing  <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (bit_ready) begin
                        if (pending != '0) begin
                            bit_out <= follow;
                            pending <= pending - 1'b1;
                        end else begin
                            bit_valid <= 1'b0;
                            if (flushing) begin
                                flushing       <= 1'b0;
                                terminate_flag <= 1'b1;
                                low            <= '0;
                                high           <= '1;
                                count          <= '0;
                                state          <= S_READY;
                            end else begin
                                state          <= S_SCALE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_encoder_param.sv
// Directed bench for arith_encoder_param: one instance with BLOCK_LEN=1 for
// hand-computed bit sequences, one with BLOCK_LEN=96 for a two-block run
// checked against a reference encoder and decoder.
module tb_arith_encoder_param;
    logic       sys_clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [3:0] cfg_freq = '0;
    logic       cfg_start = 1'b0;

    logic [2:0] sym_in1 = '0;
    logic       sym_valid1 = 1'b0, bit_ready1 = 1'b1;
    logic       sym_ready1, bit_out1, bit_valid1, term1, busy1, cfg_err1, sym_err1;
    logic [2:0] sym_in96 = '0;
    logic       sym_valid96 = 1'b0, bit_ready96 = 1'b1;
    logic       sym_ready96, bit_out96, bit_valid96, term96, busy96, cfg_err96, sym_err96;

    int checks = 0, errors = 0;
    int ftab [8];
    bit q1[$];
    bit q96[$];
    int nterm1 = 0, nterm96 = 0, b1len = 0;

    always #5 sys_clk = ~sys_clk;

    arith_encoder_param #(.SYM_W(3), .N(8), .TOT_W(3), .BLOCK_LEN(1)) u1 (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .cfg_start(cfg_start), .sym_in(sym_in1), .sym_valid(sym_valid1),
        .sym_ready(sym_ready1), .bit_out(bit_out1), .bit_valid(bit_valid1), .bit_ready(bit_ready1),
        .terminate_flag(term1), .busy(busy1), .cfg_error(cfg_err1), .sym_error(sym_err1));

    arith_encoder_param #(.SYM_W(3), .N(8), .TOT_W(3), .BLOCK_LEN(96)) u96 (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .cfg_start(cfg_start), .sym_in(sym_in96), .sym_valid(sym_valid96),
        .sym_ready(sym_ready96), .bit_out(bit_out96), .bit_valid(bit_valid96), .bit_ready(bit_ready96),
        .terminate_flag(term96), .busy(busy96), .cfg_error(cfg_err96), .sym_error(sym_err96));

    // Bit / terminate monitors: handshake values are stable across the edge.
    always @(posedge sys_clk) begin
        if (bit_valid1 && bit_ready1) q1.push_back(bit_out1);
        if (term1) nterm1++;
        if (bit_valid96 && bit_ready96) q96.push_back(bit_out96);
        if (term96) begin
            if (nterm96 == 0) b1len = q96.size();
            nterm96++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pack(input bit q[$]);
        int r = 0;
        foreach (q[i]) r = (r << 1) | int'(q[i]);
        return r;
    endfunction

    function automatic int nb(input bit b[$], input int p);
        return (p < b.size()) ? int'(b[p]) : 0;
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        sys_reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_freq = ftab[i][3:0];
            @(negedge sys_clk);
        end
        cfg_we = 1'b0;
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic send1(input logic [2:0] s);
        int k = 0;
        sym_in1 = s; sym_valid1 = 1'b1;
        while (!sym_ready1 && k < 500) begin @(negedge sys_clk); k++; end
        check("send1_ready", sym_ready1, 1);
        @(negedge sys_clk);
        sym_valid1 = 1'b0;
    endtask

    task automatic send96(input logic [2:0] s);
        int k = 0;
        sym_in96 = s; sym_valid96 = 1'b1;
        while (!sym_ready96 && k < 500) begin @(negedge sys_clk); k++; end
        check("send96_ready", sym_ready96, 1);
        @(negedge sys_clk);
        sym_valid96 = 1'b0;
    endtask

    task automatic wait_term1(input int n);
        int k = 0;
        while (nterm1 < n && k < 500) begin @(negedge sys_clk); k++; end
        check("term1_count", nterm1, n);
    endtask

    task automatic wait_term96(input int n);
        int k = 0;
        while (nterm96 < n && k < 5000) begin @(negedge sys_clk); k++; end
        check("term96_count", nterm96, n);
    endtask

    task automatic wait_valid1();
        int k = 0;
        while (!bit_valid1 && k < 100) begin @(negedge sys_clk); k++; end
    endtask

    // Reference integer arithmetic encoder (N=8, total 8).
    task automatic model_encode(input int s[$], output bit o[$]);
        int c [9];
        int lo, hi, pend, r;
        c[0] = 0;
        for (int i = 0; i < 8; i++) c[i+1] = c[i] + ftab[i];
        lo = 0; hi = 255; pend = 0; o.delete();
        foreach (s[j]) begin
            r  = hi - lo + 1;
            hi = lo + r * c[s[j]+1] / 8 - 1;
            lo = lo + r * c[s[j]] / 8;
            for (int g = 0; g < 64; g++) begin
                if (hi < 128) begin
                    o.push_back(1'b0); repeat (pend) o.push_back(1'b1); pend = 0;
                end else if (lo >= 128) begin
                    o.push_back(1'b1); repeat (pend) o.push_back(1'b0); pend = 0;
                    lo -= 128; hi -= 128;
                end else if (lo >= 64 && hi < 192) begin
                    pend++; lo -= 64; hi -= 64;
                end else break;
                lo = 2 * lo; hi = 2 * hi + 1;
            end
        end
        pend++;
        if (lo < 64) begin o.push_back(1'b0); repeat (pend) o.push_back(1'b1); end
        else begin o.push_back(1'b1); repeat (pend) o.push_back(1'b0); end
    endtask

    // Reference decoder; bits past the end of the stream read as 0.
    task automatic model_decode(input bit b[$], input int n, output int s[$]);
        int c [9];
        int lo, hi, v, pos, r, cnt, sym;
        c[0] = 0;
        for (int i = 0; i < 8; i++) c[i+1] = c[i] + ftab[i];
        lo = 0; hi = 255; v = 0; pos = 0; s.delete();
        for (int i = 0; i < 8; i++) begin v = 2 * v + nb(b, pos); pos++; end
        for (int j = 0; j < n; j++) begin
            r   = hi - lo + 1;
            cnt = ((v - lo + 1) * 8 - 1) / r;
            sym = 0;
            for (int i = 0; i < 8; i++) if (c[i] <= cnt && cnt < c[i+1]) sym = i;
            s.push_back(sym);
            hi = lo + r * c[sym+1] / 8 - 1;
            lo = lo + r * c[sym] / 8;
            for (int g = 0; g < 64; g++) begin
                if (hi < 128) begin
                end else if (lo >= 128) begin
                    lo -= 128; hi -= 128; v -= 128;
                end else if (lo >= 64 && hi < 192) begin
                    lo -= 64; hi -= 64; v -= 64;
                end else break;
                lo = 2 * lo; hi = 2 * hi + 1;
                v = 2 * v + nb(b, pos); pos++;
            end
        end
    endtask

    initial begin
        bit got[$];
        bit mbits[$];
        bit blk1[$];
        bit blk2[$];
        int syms[$];
        int dec[$];
        int cnt, stable_err;
        logic v;

        // ---- reset state ----
        #2 sys_reset = 1'b0;
        #1;
        check("reset_outs_u1", {sym_ready1, bit_out1, bit_valid1, term1, busy1, cfg_err1, sym_err1}, 0);
        check("reset_outs_u96", {sym_ready96, bit_out96, bit_valid96, term96, busy96, cfg_err96, sym_err96}, 0);
        repeat (2) @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        check("busy_after_reset", busy1, 0);

        // ---- uniform table, symbol 5 -> 1,0,1 then flush 0,1 ----
        ftab = '{1, 1, 1, 1, 1, 1, 1, 1};
        load_table();
        check("uniform_cfg_err", cfg_err1, 0);
        check("uniform_ready", sym_ready1, 1);
        q1.delete();
        send1(3'd5);
        wait_term1(1);
        repeat (3) @(negedge sys_clk);
        check("uniform_term_once", nterm1, 1);
        check("uniform_nbits", q1.size(), 5);
        check("uniform_bits", pack(q1), 32'b10101);
        check("uniform_back_ready", sym_ready1, 1);

        // ---- backpressure: 10 stalled cycles per bit ----
        q1.delete();
        bit_ready1 = 1'b0;
        stable_err = 0;
        send1(3'd5);
        for (int b = 0; b < 5; b++) begin
            wait_valid1();
            v = bit_out1;
            for (int k = 0; k < 10; k++) begin
                @(negedge sys_clk);
                if (bit_out1 !== v || bit_valid1 !== 1'b1 || sym_ready1 !== 1'b0) stable_err++;
            end
            got.push_back(v);
            bit_ready1 = 1'b1;
            @(negedge sys_clk);
            bit_ready1 = 1'b0;
        end
        check("bp_stable", stable_err, 0);
        check("bp_bits_seen", pack(got), 32'b10101);
        check("bp_bits_accepted", pack(q1), 32'b10101);
        check("bp_nbits", q1.size(), 5);
        wait_term1(2);

        // ---- reset mid-stream ----
        send1(3'd5);
        wait_valid1();
        check("midstream_valid", bit_valid1, 1);
        sys_reset = 1'b0;
        #1;
        check("midreset_outs", {sym_ready1, bit_out1, bit_valid1, term1, busy1, cfg_err1, sym_err1}, 0);
        repeat (2) @(negedge sys_clk);
        sys_reset = 1'b1;
        bit_ready1 = 1'b1;
        @(negedge sys_clk);
        check("midreset_busy", busy1, 0);
        // Table must be cleared: starting with no writes yields a zero total.
        cfg_start = 1'b1;
        @(negedge sys_clk);
        cfg_start = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("cleared_table_err", cfg_err1, 1);
        check("cleared_table_idle", busy1, 0);
        check("no_term_on_reset", nterm1, 2);

        // ---- table total 7 ----
        do_reset();
        ftab = '{1, 1, 1, 1, 1, 1, 1, 0};
        load_table();
        check("sum7_cfg_err", cfg_err1, 1);
        check("sum7_idle", busy1, 0);
        sym_valid1 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (sym_ready1) cnt++;
        end
        sym_valid1 = 1'b0;
        check("sum7_never_ready", cnt, 0);

        // ---- zero-frequency symbol, then E3 path ----
        ftab = '{3, 2, 3, 0, 0, 0, 0, 0};
        load_table();
        check("e3_cfg_err_cleared", cfg_err1, 0);
        q1.delete();
        send1(3'd3);
        check("symerr_pulse", sym_err1, 1);
        @(negedge sys_clk);
        check("symerr_one_cycle", sym_err1, 0);
        repeat (5) @(negedge sys_clk);
        check("symerr_no_bits", q1.size(), 0);
        check("symerr_still_ready", sym_ready1, 1);
        send1(3'd1);
        wait_term1(nterm1 == 2 ? 3 : nterm1 + 1);
        check("e3_nbits", q1.size(), 4);
        check("e3_bits", pack(q1), 32'b0111);

        // ---- two 96-symbol blocks ----
        do_reset();
        ftab = '{1, 2, 1, 1, 1, 1, 0, 1};
        load_table();
        check("blk_ready", sym_ready96, 1);
        q96.delete();
        for (int j = 0; j < 96; j++) begin
            int s;
            s = $urandom_range(0, 7);
            while (ftab[s] == 0) s = $urandom_range(0, 7);
            syms.push_back(s);
        end
        for (int j = 0; j < 96; j++) send96(3'(syms[j]));
        for (int j = 0; j < 96; j++) send96(3'(syms[j]));
        wait_term96(2);
        repeat (20) @(negedge sys_clk);
        check("blk_term_twice", nterm96, 2);
        for (int i = 0; i < q96.size(); i++) begin
            if (i < b1len) blk1.push_back(q96[i]); else blk2.push_back(q96[i]);
        end
        model_encode(syms, mbits);
        check("blk1_len", blk1.size(), mbits.size());
        cnt = 0;
        foreach (mbits[i]) if (i >= blk1.size() || blk1[i] !== mbits[i]) cnt++;
        check("blk1_vs_model", cnt, 0);
        check("blk2_len", blk2.size(), blk1.size());
        cnt = 0;
        foreach (blk1[i]) if (i >= blk2.size() || blk2[i] !== blk1[i]) cnt++;
        check("blk2_vs_blk1", cnt, 0);
        model_decode(blk1, 96, dec);
        cnt = 0;
        foreach (syms[i]) if (dec[i] != syms[i]) cnt++;
        check("blk1_decode", cnt, 0);
        model_decode(blk2, 96, dec);
        cnt = 0;
        foreach (syms[i]) if (dec[i] != syms[i]) cnt++;
        check("blk2_decode", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_encoder_param.md
Name: arith_encoder_param

Overview:
Parametrised integer arithmetic encoder, the successor to the fixed 3-bit/N=8 encoder. It has a programmable static frequency table, and the alphabet size, word length and block length are all parameters. Symbols enter on a valid/ready handshake and the code bits leave as a serial valid/ready stream with backpressure. Each block of BLOCK_LEN symbols is closed with a termination sequence and a terminate_flag pulse, then the coder re-initialises for the next block.

Parameters:
SYM_W, 3, symbol width; alphabet size is 2^SYM_W
N, 8, low/high register width; must satisfy N >= TOT_W+2
TOT_W, 3, table total is fixed at 2^TOT_W, so the model division is a right shift by TOT_W
BLOCK_LEN, 96, symbols per block before termination

Ports:
sys_clk  in  1  clock
sys_reset  in  1  asynchronous active-low reset
cfg_we  in  1  write freq[cfg_addr] (honoured in IDLE only)
cfg_addr  in  SYM_W  table index
cfg_freq  in  TOT_W+1  frequency value
cfg_start  in  1  pulse: build cumulative table, then start coding
sym_in  in  SYM_W  symbol
sym_valid  in  1  symbol offered
sym_ready  out  1  encoder accepts symbol this cycle
bit_out  out  1  code bit
bit_valid  out  1  bit_out valid
bit_ready  in  1  sink accepts bit
terminate_flag  out  1  1-cycle pulse after a block's last bit is accepted
busy  out  1  state != IDLE
cfg_error  out  1  sticky: table total != 2^TOT_W; cleared by next cfg_start
sym_error  out  1  1-cycle pulse: a symbol with freq 0 was received

Behaviour:
- Reset (async, sys_reset=0): state IDLE; all outputs 0; low=0; high=2^N-1; pending=0; symbol count=0; freq table cleared to 0.
- IDLE: cfg_we writes freq. On cfg_start go to CUMSUM.
- CUMSUM: one table entry per cycle, 2^SYM_W cycles. cum[0]=0 and cum[i+1]=cum[i]+freq[i], held at TOT_W+2 bits.
  - If the final sum != 2^TOT_W: set cfg_error, return to IDLE.
  - Otherwise go to READY.
- READY: sym_ready=1. A symbol is accepted when sym_valid and sym_ready are both high.
  - If freq[sym]=0: pulse sym_error, drop the symbol, leave the count unchanged, stay in READY.
  - Otherwise go to UPDATE.
- UPDATE (1 cycle): compute range=high-low+1 at N+1 bits, with the products at full width.
  - high' = low + ((range*cum[s+1])>>TOT_W) - 1
  - low' = low + ((range*cum[s])>>TOT_W)
  - Increment the count, then go to SCALE.
- SCALE: evaluate one condition per step, in priority order.
  - E1 (high < HALF): emit 0, then pending 1s.
  - E2 (low >= HALF): emit 1, then pending 0s; subtract HALF from low and high.
  - E3 (low >= QTR and high < 3QTR): pending+1 (no bit); subtract QTR from low and high.
  - After every case: low=2*low, high=2*high+1.
  - No condition holds: go to FLUSH if count==BLOCK_LEN, else READY.
  - HALF=2^(N-1), QTR=2^(N-2).
- Bit emission:
  - bit_valid is held with bit_out stable until bit_ready; one bit per handshake cycle.
  - The scaling step and pending countdown stall while a bit is unaccepted.
  - sym_ready=0 outside READY.
- FLUSH: pending+1. If low < QTR, emit 0 then pending 1s; otherwise emit 1 then pending 0s.
- After the last flush bit is accepted: pulse terminate_flag for 1 cycle, reset low/high/pending/count to their initial values, and go to READY. The table is retained.
- pending counter is N bits wide and saturates; it does not wrap.
- cfg_we outside IDLE is ignored.
- cfg_start outside IDLE is ignored.
- Reset mid-block aborts immediately. No termination sequence is emitted.

Test Plan:
- Reset check: assert sys_reset=0 mid-stream -> all outputs 0 at once; after release, busy=0 and the table is cleared.
- Uniform table, exact case: N=8, TOT_W=3, SYM_W=3, freq=1 for all 8 symbols, BLOCK_LEN=1; send sym 5 -> bits 1,0,1 (state 160/191 → 0/255), then flush bits 0,1, then terminate_flag. Expect exactly 5 bits.
- E3 (underflow) path: freq={3,2,3,0,0,0,0,0}, BLOCK_LEN=1; send sym 1 -> low/high 96/159, two E3 steps with pending=2, flush bits 0,1,1,1, then terminate_flag.
- Backpressure: repeat the uniform-table case with bit_ready low for 10 cycles per bit -> bit_out and bit_valid stay stable while stalled, sym_ready=0, and the bit sequence is identical.
- Table errors:
  - freq sum 7 -> cfg_error=1, returns to IDLE, sym_ready never asserts.
  - Valid table with freq[3]=0, send sym 3 -> sym_error pulse, no bits emitted, count unchanged.
- Multi-block run: BLOCK_LEN=96, stream 96 random symbols twice -> terminate_flag pulses exactly twice. The bitstreams decode, via the golden model, back to the input, and the second block's bits are identical to the first's when fed the same symbols.
